// File: rtl/aes_pkg.sv
// Shared AES-128 constants, key-prep FSM encoding and GF(2^8) helpers.
package aes_pkg;

  localparam int         AES_NB_ROUNDS  = 10;
  localparam logic [7:0] AES_RCON_FIRST = 8'h01;
  localparam logic [7:0] AES_RCON_LAST  = 8'h36;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } aes_state_e;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = xtime(sh);
    end
    return acc;
  endfunction

  // S-box as multiplicative inverse (x^254, so 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] e;
    e   = 8'hfe;
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gf_mul(inv, inv);
      if (e[i]) inv = gf_mul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_fwd_round.sv
// One forward AES-128 key-expansion round; the inverse scheduler undoes exactly this step.
module aes_key_fwd_round
  import aes_pkg::*;
(
  input  logic [127:0] key_i,
  input  logic [7:0]   key_rcon_i,
  output logic [127:0] key_next_o,
  output logic [7:0]   key_rcon_o
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot_w3, sub_w;
  logic [31:0] n0, n1, n2, n3;

  assign {w0, w1, w2, w3} = key_i;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .data (rot_w3[8*g +: 8]),
      .sub  (sub_w[8*g +: 8])
    );
  end

  assign n0 = w0 ^ sub_w ^ {key_rcon_i, 24'h0};
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_next_o = {n0, n1, n2, n3};
  assign key_rcon_o = xtime(key_rcon_i);

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, single byte, purely combinational.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data,
  output logic [7:0] sub
);

  assign sub = sbox_calc(data);

endmodule

// File: rtl/aes_dec_key_prep.sv
// Expands an AES-128 cipher key to its round-10 key for the inverse scheduler; optional cache via AES_DEC_KEY_CACHE_EN.
// States: IDLE = ready for key | EXPAND = one forward round per cycle | DONE = presenting round-10 key.
module aes_dec_key_prep
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         key_v_i,
  input  logic [127:0] key_i,
  output logic         key_rdy_o,
  output logic         dec_key_v_o,
  output logic [127:0] dec_key_o,
  output logic [7:0]   dec_rcon_o,
  input  logic         dec_key_rdy_i
);

  aes_state_e   state, state_nxt;
  logic [3:0]   round;
  logic [127:0] work_key;
  logic [7:0]   work_rcon;
  logic [127:0] round_key;
  logic [7:0]   round_rcon;
  logic         accept, handoff, last_round, cache_hit;
  logic         rdy_nxt, v_nxt, load_done;
  logic [127:0] done_key;
  logic [7:0]   done_rcon;

  aes_key_fwd_round u_fwd_round (
    .key_i      (work_key),
    .key_rcon_i (work_rcon),
    .key_next_o (round_key),
    .key_rcon_o (round_rcon)
  );

  assign accept     = key_v_i & key_rdy_o;
  assign handoff    = dec_key_v_o & dec_key_rdy_i;
  assign last_round = (round == 4'(AES_NB_ROUNDS));

`ifdef AES_DEC_KEY_CACHE_EN
  logic         cache_v;
  logic [127:0] cache_key, cache_rk, pend_key;

  assign cache_hit = cache_v & (key_i == cache_key);

  always_ff @(posedge clk) begin
    if (reset) begin
      cache_v <= 1'b0;
    end else begin
      if (state == IDLE && accept) pend_key <= key_i;
      if (state == EXPAND && last_round) begin
        cache_v   <= 1'b1;
        cache_key <= pend_key;
        cache_rk  <= round_key;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = cache_hit ? DONE : EXPAND;
      EXPAND:  if (last_round) state_nxt = DONE;
      DONE:    if (handoff) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    rdy_nxt   = (state_nxt == IDLE);
    v_nxt     = (state_nxt == DONE);
    load_done = (state != DONE) && (state_nxt == DONE);
    done_key  = round_key;
    done_rcon = work_rcon;
`ifdef AES_DEC_KEY_CACHE_EN
    if (state == IDLE) begin
      done_key  = cache_rk;
      done_rcon = AES_RCON_LAST;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      round     <= 4'd0;
      work_key  <= 128'h0;
      work_rcon <= 8'h00;
    end else begin
      case (state)
        IDLE: if (accept) begin
          work_key  <= key_i;
          work_rcon <= AES_RCON_FIRST;
          round     <= 4'd1;
        end
        EXPAND: begin
          work_key  <= round_key;
          work_rcon <= round_rcon;
          round     <= round + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered off the next state so they track state with no input-to-output path.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_rdy_o   <= 1'b1;
      dec_key_v_o <= 1'b0;
      dec_key_o   <= 128'h0;
      dec_rcon_o  <= 8'h00;
    end else begin
      key_rdy_o   <= rdy_nxt;
      dec_key_v_o <= v_nxt;
      if (load_done) begin
        dec_key_o  <= done_key;
        dec_rcon_o <= done_rcon;
      end
    end
  end

endmodule

// File: tb/tb_aes_dec_key_prep.sv
// Self-checking bench for aes_dec_key_prep; cache checks compile in with AES_DEC_KEY_CACHE_EN.
module tb_aes_dec_key_prep;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_v_i;
  logic [127:0] key_i;
  logic         key_rdy_o;
  logic         dec_key_v_o;
  logic [127:0] dec_key_o;
  logic [7:0]   dec_rcon_o;
  logic         dec_key_rdy_i;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [127:0] key;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    logic [127:0] key;
    logic [7:0]   rcon;
  } exp_t;

  vec_t         vecs[3];
  exp_t         sb_q[$];
  logic [127:0] last_key;
  logic [7:0]   last_rcon;
  logic [2047:0] sbox_tbl;

  localparam logic [2047:0] SBOX_HEX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  always #5 clk = ~clk;

  aes_dec_key_prep dut (
    .clk           (clk),
    .reset         (reset),
    .key_v_i       (key_v_i),
    .key_i         (key_i),
    .key_rdy_o     (key_rdy_o),
    .dec_key_v_o   (dec_key_v_o),
    .dec_key_o     (dec_key_o),
    .dec_rcon_o    (dec_rcon_o),
    .dec_key_rdy_i (dec_key_rdy_i)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] sb(input logic [7:0] x);
    return sbox_tbl[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [127:0] inv_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3, t;
    {w0, w1, w2, w3} = k;
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    t  = {p3[23:0], p3[31:24]};
    p0 = w0 ^ {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  function automatic logic [7:0] inv_xtime(input logic [7:0] r);
    return (r == 8'h1b) ? 8'h80 : {1'b0, r[7:1]};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      check({name, "_queue"}, 128'(dec_key_v_o), 128'(0));
    end else begin
      e = sb_q.pop_front();
      check({name, "_key"}, dec_key_o, e.key);
      check({name, "_rcon"}, 128'(dec_rcon_o), 128'(e.rcon));
    end
  endtask

  // Latency counts edges with the accepting edge as edge 1.
  task automatic run_key(input logic [127:0] k, input logic [127:0] exp,
                         input int exp_lat, input string name);
    int guard;
    int lat;
    guard = 0;
    while (!key_rdy_o && guard < 40) begin
      tick();
      guard++;
    end
    check({name, "_rdy"}, 128'(key_rdy_o), 128'(1));
    key_v_i = 1'b1;
    key_i   = k;
    sb_q.push_back('{key: exp, rcon: 8'h36});
    tick();
    key_v_i = 1'b0;
    key_i   = {$urandom(), $urandom(), $urandom(), $urandom()};
    lat = 1;
    while (!dec_key_v_o && lat < 40) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, 128'(lat), 128'(exp_lat));
    last_key  = dec_key_o;
    last_rcon = dec_rcon_o;
    if (dec_key_v_o) pop_check(name);
    else void'(sb_q.pop_front());
    if (dec_key_rdy_i) begin
      tick();
      check({name, "_rdy_after"}, 128'(key_rdy_o), 128'(1));
      check({name, "_v_after"}, 128'(dec_key_v_o), 128'(0));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ck;
    logic [7:0]   cr;
    int           acc_edge[$];
    int           guard;
    logic         will_accept;
    int           sel;

    sbox_tbl = SBOX_HEX;
    vecs[0] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c, exp: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{key: 128'h000102030405060708090a0b0c0d0e0f, exp: 128'h13111d7fe3944a17f307a78b4d2b30c5};
    vecs[2] = '{key: 128'h00000000000000000000000000000000, exp: 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

    reset = 1'b1;
    key_v_i = 1'b0;
    key_i = 128'h0;
    dec_key_rdy_i = 1'b1;
    tick();
    tick();
    check("reset_rdy", 128'(key_rdy_o), 128'(1));
    check("reset_v", 128'(dec_key_v_o), 128'(0));
    check("reset_key", dec_key_o, 128'h0);
    check("reset_rcon", 128'(dec_rcon_o), 128'(0));
    reset = 1'b0;
    tick();

    for (int i = 0; i < 3; i++) begin
      run_key(vecs[i].key, vecs[i].exp, 11, $sformatf("vec%0d", i));
      if (i == 0) begin
        ck = last_key;
        cr = last_rcon;
        for (int s = 1; s <= 10; s++) begin
          if (s == 10) check("chain_rcon_before_last", 128'(cr), 128'(8'h01));
          ck = inv_step(ck, cr);
          cr = inv_xtime(cr);
        end
        check("chain_cipher_key", ck, vecs[0].key);
      end
    end

    // Stalled consumer: outputs hold, new keys are ignored.
    dec_key_rdy_i = 1'b0;
    key_v_i = 1'b1;
    key_i = vecs[1].key;
    sb_q.push_back('{key: vecs[1].exp, rcon: 8'h36});
    tick();
    key_v_i = 1'b0;
    guard = 0;
    while (!dec_key_v_o && guard < 40) begin
      tick();
      guard++;
    end
    for (int i = 0; i < 20; i++) begin
      key_v_i = i[0];
      key_i = vecs[2].key;
      tick();
      check("stall_v", 128'(dec_key_v_o), 128'(1));
      check("stall_rdy", 128'(key_rdy_o), 128'(0));
      check("stall_key", dec_key_o, vecs[1].exp);
      check("stall_rcon", 128'(dec_rcon_o), 128'(8'h36));
    end
    key_v_i = 1'b0;
    pop_check("stall");
    dec_key_rdy_i = 1'b1;
    tick();
    check("stall_release_rdy", 128'(key_rdy_o), 128'(1));
    check("stall_release_v", 128'(dec_key_v_o), 128'(0));
    tick();
    tick();
    check("stall_no_ghost_rdy", 128'(key_rdy_o), 128'(1));
    check("stall_no_ghost_v", 128'(dec_key_v_o), 128'(0));

    // Back-to-back with alternating keys: acceptance every 12 edges.
    sel = 0;
    key_v_i = 1'b1;
    key_i = vecs[0].key;
    for (int e = 1; e <= 40; e++) begin
      will_accept = key_rdy_o && key_v_i;
      if (dec_key_v_o) pop_check("b2b");
      if (will_accept) begin
        sb_q.push_back('{key: vecs[sel].exp, rcon: 8'h36});
        acc_edge.push_back(e);
      end
      tick();
      if (will_accept) begin
        sel = 1 - sel;
        key_i = vecs[sel].key;
      end
    end
    key_v_i = 1'b0;
    guard = 0;
    while (sb_q.size() > 0 && guard < 40) begin
      if (dec_key_v_o) pop_check("b2b_drain");
      tick();
      guard++;
    end
    check("b2b_drain_done", 128'(sb_q.size()), 128'(0));
    check("b2b_accept_count", 128'(acc_edge.size()), 128'(4));
    if (acc_edge.size() >= 3) begin
      check("b2b_period_1", 128'(acc_edge[1] - acc_edge[0]), 128'(12));
      check("b2b_period_2", 128'(acc_edge[2] - acc_edge[1]), 128'(12));
    end
    sb_q.delete();

    // Reset during round 5 discards the key.
    guard = 0;
    while (!key_rdy_o && guard < 40) begin
      tick();
      guard++;
    end
    key_v_i = 1'b1;
    key_i = vecs[1].key;
    tick();
    key_v_i = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_rdy", 128'(key_rdy_o), 128'(1));
    check("midreset_v", 128'(dec_key_v_o), 128'(0));
    check("midreset_key", dec_key_o, 128'h0);
    check("midreset_rcon", 128'(dec_rcon_o), 128'(0));
    run_key(vecs[2].key, vecs[2].exp, 11, "after_reset");

`ifdef AES_DEC_KEY_CACHE_EN
    run_key(vecs[2].key, vecs[2].exp, 1, "cache_hit_zero");
    run_key(vecs[0].key, vecs[0].exp, 11, "cache_miss_fips");
    run_key(vecs[0].key, vecs[0].exp, 1, "cache_hit_fips");
    do_reset();
    run_key(vecs[0].key, vecs[0].exp, 11, "cache_cleared");
`else
    run_key(vecs[2].key, vecs[2].exp, 11, "repeat_key");
    do_reset();
    run_key(vecs[0].key, vecs[0].exp, 11, "after_reset2");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes_dec_key_prep.md
# aes_dec_key_prep

Sequential key-preparation stage upstream of the inverse key scheduler. It accepts a 128-bit AES cipher key, iterates the forward key expansion one round per cycle for 10 rounds, and presents the round-10 key with its rcon (8'h36). The inverse scheduler uses these as its starting key and rcon, one inverse step per decryption round.

## Interface
- No parameters (AES-128 only; round count fixed at 10).
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- key_v_i  input  1  cipher key valid
- key_i  input  128  cipher key; [127:96] = w0, [31:0] = w3
- key_rdy_o  output  1  block can accept a key
- dec_key_v_o  output  1  decryption start key valid
- dec_key_o  output  128  round-10 key, same word layout as key_i
- dec_rcon_o  output  8  rcon for inverse scheduler's first step
- dec_key_rdy_i  input  1  consumer accepts dec_key_o

Clock and reset are named as elsewhere in the codebase. Reset is synchronous and active-high.

## Operation
- FSM states:
  - IDLE: key_rdy_o=1.
  - EXPAND: round counter runs 1..10.
  - DONE: dec_key_v_o=1.
- IDLE: when key_v_i & key_rdy_o, register key_i into the working key, set rcon=8'h01 and round counter=1, go to EXPAND.
- EXPAND: each cycle perform one forward round, rcon 01→02→…→80→1b→36.
  - w0' = w0 ^ SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
  - RotWord is a left byte rotation.
  - rcon advances by xtime: shift left, with 8'h80 → 8'h1b.
  - After round 10, go to DONE.
- DONE:
  - dec_key_o = round-10 key, dec_rcon_o = 8'h36 (the rcon consumed by round 10).
  - Outputs are held stable until dec_key_v_o & dec_key_rdy_i, then go to IDLE.
- key_v_i is ignored outside IDLE. key_i is sampled only on the accepting edge.
- Reset, including mid-EXPAND or mid-DONE:
  - state → IDLE, key_rdy_o=1, dec_key_v_o=0, dec_key_o=128'h0, dec_rcon_o=8'h00.
  - Any in-flight key is discarded.

## Timing
- key_rdy_o and dec_key_v_o are registered and decode from state only. No combinational path exists from any input to any output.
- Latency: dec_key_v_o rises on the 11th rising edge after the accepting edge. The 10 EXPAND cycles begin with the cycle after acceptance.
- Handoff edge (valid & ready): DONE→IDLE. key_rdy_o=1 in the next cycle. Back-to-back period is 12 cycles.
- dec_key_rdy_i high before DONE has no effect.
- dec_key_o/dec_rcon_o change only on the edge entering DONE, and on reset.

## Configuration
- AES_DEC_KEY_CACHE_EN defined:
  - Keep the cipher key of the last completed expansion, its round-10 key, and a cache-valid bit. Reset clears the valid bit.
  - On acceptance with a valid cache and key_i equal to the cached key: go IDLE→DONE directly. dec_key_v_o rises on the first edge after acceptance, with the cached round-10 key and rcon 8'h36.
  - A mismatch runs the normal 10-round expansion, then refreshes the cache when entering DONE.
- Undefined: no cache storage, and every key takes the full 10-round latency.

## Structure
- Shared package aes_pkg holds:
  - AES_NB_ROUNDS=10
  - AES_RCON_FIRST=8'h01
  - AES_RCON_LAST=8'h36
  - FSM state encoding (IDLE/EXPAND/DONE)
- One combinational sub-module, aes_key_fwd_round:
  - inputs key_i[127:0], key_rcon_i[7:0]; outputs key_next_o[127:0], key_rcon_o[7:0]
  - uses four aes_sbox instances on the rotated w3
  - is the exact forward counterpart of the inverse step.
- The top level contains the FSM, round counter, working key/rcon registers, output registers, and the optional cache.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with dec_key_rdy_i=1 → dec_key_o=d014f9a8c9ee2589e13f0cc8b6630ca6 and dec_rcon_o=8'h36, 11 edges after acceptance.
- Key 000102030405060708090a0b0c0d0e0f → 13111d7fe3944a17f307a78b4d2b30c5; all-zero key → b4ef5bcb3e92e21123e951cf6f8f188e.
- dec_key_rdy_i held low 20 cycles → dec_key_v_o/outputs stable, key_rdy_o=0, key_v_i pulses ignored; raising ready → IDLE next cycle.
- Reset asserted at round 5 → next cycle key_rdy_o=1, dec_key_v_o=0, dec_key_o=0, dec_rcon_o=0; a new key then completes normally.
- Chaining: feed dec_key_o/dec_rcon_o through 10 inverse steps → original cipher key and rcon ends 8'h01 before last step.
- With AES_DEC_KEY_CACHE_EN: same FIPS key twice → second result 1 edge after acceptance; a different key → 11 edges; reset then the same key → 11 edges.
